// File: rtl/btn_evt.sv
// Button event decoder: turns a debounced level into press/release/long/repeat/double-click pulses.
// Auto-repeat in the long-hold state is built only when BTN_EVT_REPEAT_EN is defined.
module btn_evt #(
  parameter int unsigned LONG_CYC = 1000,
  parameter int unsigned REPT_CYC = 200,
  parameter int unsigned DBL_CYC  = 300
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btnq_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic rept_o,
  output logic dbl_o,
  output logic hold_o
);

  if (LONG_CYC < 2 || LONG_CYC > 65535 || REPT_CYC < 2 || REPT_CYC > 65535 ||
      DBL_CYC < 2 || DBL_CYC > 65535) begin : g_param_check
    $error("btn_evt: cycle parameters must lie in 2..65535");
  end

  typedef enum logic [2:0] {StIdle, StDown, StUpWait, StDown2, StLongH} state_e;

  // Thresholds are compared one cycle early because every output is registered.
  localparam logic [15:0] LongLast = 16'(LONG_CYC - 1);
  localparam logic [15:0] DblLast  = 16'(DBL_CYC - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic        s_q, s_dly_q;
  logic        rise, fall;
  logic        press_q, release_q, long_q, dbl_q, hold_q;

  assign rise    = s_q & ~s_dly_q;
  assign fall    = ~s_q & s_dly_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [15:0] ReptLast = 16'(REPT_CYC - 1);
  logic rept_q;
  assign rept_o = rept_q;
`else
  assign rept_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      s_dly_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      dbl_q     <= 1'b0;
      hold_q    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rept_q    <= 1'b0;
`endif
    end else begin
      s_q       <= btnq_i;
      s_dly_q   <= s_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      dbl_q     <= 1'b0;
      cnt_q     <= cnt_inc;
`ifdef BTN_EVT_REPEAT_EN
      rept_q    <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rise) begin
            press_q <= 1'b1;
            hold_q  <= 1'b1;
            state_q <= StDown;
          end
        end
        StDown, StDown2: begin
          // Release wins over a coincident long threshold.
          if (fall) begin
            release_q <= 1'b1;
            hold_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= (state_q == StDown) ? StUpWait : StIdle;
          end else if (cnt_q == LongLast) begin
            long_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StLongH;
          end
        end
        StUpWait: begin
          // A rise on the expiry cycle still counts as a double click.
          if (rise) begin
            press_q <= 1'b1;
            dbl_q   <= 1'b1;
            hold_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StDown2;
          end else if (cnt_q == DblLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        StLongH: begin
          if (fall) begin
            release_q <= 1'b1;
            hold_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StIdle;
          end
`ifdef BTN_EVT_REPEAT_EN
          else if (cnt_q == ReptLast) begin
            rept_q <= 1'b1;
            cnt_q  <= '0;
          end
`endif
        end
        default: begin
          cnt_q   <= '0;
          hold_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign dbl_o     = dbl_q;
  assign hold_o    = hold_q;

endmodule

// File: doc/btn_evt.md
BTN_EVT -- requirements
Module: btn_evt

Interface
REQ-001 SHALL have parameter LONG_CYC, default 1000, meaning hold cycles from PRESS to LONG (valid range 2..65535).
REQ-002 SHALL have parameter REPT_CYC, default 200, meaning cycles between auto-repeat pulses (valid range 2..65535).
REQ-003 SHALL have parameter DBL_CYC, default 300, meaning the double-click window in cycles after RELEASE (valid range 2..65535).
REQ-004 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port BTNQ  input  1  debounced button level from the button filter stage, high = pressed.
REQ-007 SHALL have port PRESS  output  1  one-cycle pulse on button press.
REQ-008 SHALL have port RELEASE  output  1  one-cycle pulse on button release.
REQ-009 SHALL have port LONG  output  1  one-cycle pulse when a press is held LONG_CYC cycles.
REQ-010 SHALL have port REPT  output  1  one-cycle auto-repeat pulse during a long hold.
REQ-011 SHALL have port DBL  output  1  one-cycle pulse on a second press inside the double-click window.
REQ-012 SHALL have port HOLD  output  1  level, high in states DOWN, DOWN2 and LONGH.

Function
REQ-013 SHALL sample BTNQ into a 2-stage register (s, s_d); rise = s & ~s_d, fall = ~s & s_d.
REQ-014 SHALL register all outputs; PRESS/RELEASE go high on the 2nd rising CLK edge after the BTNQ transition and stay high exactly 1 cycle.
REQ-015 SHALL implement states IDLE, DOWN, UPWAIT, DOWN2 and LONGH, plus one 16-bit saturating counter cleared on every state change.
REQ-016 IDLE: on rise SHALL pulse PRESS and go to DOWN.
REQ-017 DOWN: on fall SHALL pulse RELEASE and go to UPWAIT; when held, LONG SHALL pulse at cycle k+LONG_CYC (k = PRESS cycle) and the state SHALL go to LONGH.
REQ-018 UPWAIT: on rise at cycle ≤ r+DBL_CYC (r = RELEASE cycle) SHALL pulse PRESS and DBL together and go to DOWN2; otherwise it SHALL return to IDLE at r+DBL_CYC.
REQ-019 DOWN2: SHALL behave as DOWN, except that fall pulses RELEASE and goes to IDLE, so no DBL chains into a triple click.
REQ-020 LONGH: fall SHALL pulse RELEASE and go to IDLE; no double-click window SHALL open after a long press.
REQ-021 Simultaneous events: fall and the LONG threshold in the same cycle SHALL produce RELEASE only; rise and UPWAIT expiry in the same cycle SHALL produce DBL.
REQ-022 At most one of PRESS/RELEASE SHALL be high in any cycle; LONG and REPT SHALL never coincide.
REQ-023 The counter SHALL never wrap; it saturates at 16'hFFFF.

Reset
REQ-024 RST low SHALL immediately force state IDLE, counter 0, s = s_d = 0, and all outputs (PRESS, RELEASE, LONG, REPT, DBL, HOLD) to 0.
REQ-025 Reset asserted mid-press SHALL abandon the event with no RELEASE; if BTNQ is still high after reset release, PRESS SHALL pulse on the 2nd edge after release.

Configuration
REQ-026 Macro BTN_EVT_REPEAT_EN defined: in LONGH, REPT SHALL pulse at k+LONG_CYC+n*REPT_CYC for n = 1, 2, ... until fall.
REQ-027 BTN_EVT_REPEAT_EN undefined: REPT SHALL be tied 0, the repeat logic SHALL be absent, and LONGH only waits for fall.

Verification (bench parameters LONG_CYC=20, REPT_CYC=5, DBL_CYC=10, CLK period 10)
REQ-028 Press held 8 cycles -> PRESS at k, HOLD high, RELEASE at k+8, no LONG/DBL; IDLE at k+18.
REQ-029 Press held 40 cycles with REPEAT_EN -> LONG at k+20, REPT at k+25, k+30, k+35, RELEASE at k+40, no DBL window; without the macro, REPT stays 0.
REQ-030 Release, then re-press with PRESS at r+10 -> DBL with that PRESS; re-press at r+11 -> PRESS only; a third click right after DBL -> no DBL.
REQ-031 Release exactly at cycle k+20 -> RELEASE only, LONG never pulses.
REQ-032 RST low at k+5 mid-press -> all outputs 0 asynchronously, no RELEASE; BTNQ held high through reset release -> PRESS 2 edges after release.
